// File: rtl/serial_link_rx_credit_buffer.sv
// rtl/serial_link_rx_credit_buffer.sv - receive FIFO with batched/timed credit return
// Registered circular buffer for a backpressure-free link; freed slots returned as credits.
module serial_link_rx_credit_buffer #(
  parameter int DataWidth = 8,
  parameter int Depth     = 8,
  parameter int BatchSize = 4,
  parameter int Timeout   = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         valid_i,
  input  logic [DataWidth-1:0]         data_i,
  output logic                         out_valid_o,
  output logic [DataWidth-1:0]         out_data_o,
  input  logic                         out_ready_i,
  output logic                         credit_valid_o,
  output logic [$clog2(Depth+1)-1:0]   credit_count_o,
  output logic [$clog2(Depth+1)-1:0]   fill_o,
  output logic                         overflow_o
);

  localparam int CW = $clog2(Depth + 1);
  localparam int PW = $clog2(Depth);
  localparam int TW = $clog2(Timeout) + 1;

  localparam logic [CW-1:0] DepthC    = CW'(Depth);
  localparam logic [CW-1:0] BatchC    = CW'(BatchSize);
  localparam logic [PW-1:0] PtrLast   = PW'(Depth - 1);
  localparam logic [TW-1:0] TimerLast = TW'(Timeout - 1);

  logic [DataWidth-1:0] mem [Depth];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        fill;
  logic [CW-1:0]        cnt;
  logic [TW-1:0]        timer;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 flush;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PtrLast) ? '0 : p + PW'(1);
  endfunction

  assign full  = (fill == DepthC);
  assign pop   = (fill != '0) && out_ready_i;
  // A pop in the same cycle frees the slot, so a full buffer can still accept.
  assign push  = valid_i && (!full || pop);
  assign flush = (cnt >= BatchC) || ((cnt != '0) && (timer == TimerLast));

  assign out_valid_o = (fill != '0);
  assign out_data_o  = mem[rd_ptr];
  assign fill_o      = fill;

  always_ff @(posedge clk_i) begin
    if (push && !rst_i) begin
      mem[wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fill       <= '0;
      overflow_o <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   fill <= fill + CW'(1);
        2'b01:   fill <= fill - CW'(1);
        default: fill <= fill;
      endcase
      if (valid_i && full && !pop) begin
        overflow_o <= 1'b1;
      end
    end
  end

  // Credits count pops only, so dropped words never produce credits.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt            <= '0;
      timer          <= '0;
      credit_valid_o <= 1'b0;
      credit_count_o <= '0;
    end else if (flush) begin
      credit_valid_o <= 1'b1;
      credit_count_o <= cnt;
      cnt            <= CW'(pop);
      timer          <= '0;
    end else begin
      credit_valid_o <= 1'b0;
      credit_count_o <= '0;
      cnt            <= cnt + CW'(pop);
      timer          <= (cnt != '0) ? timer + TW'(1) : '0;
    end
  end

endmodule
